counter_event_log: RTL and testbench

Timestamped event recorder that sits directly downstream of the counter logic. It consumes the counters' one-cycle compare strobes (count==00, count==80, count==FF, …) together with the associated 8-bit count value. Each event is stamped with a free-running 16-bit cycle timestamp and stored in a small FIFO, which the host drains one record at a time through a wire-out/trigger-in pair. This replaces edge-only trigger-outs when the host needs ordering, timing and loss information.

---
 rtl/counter_log_pkg.sv | 35 +++
 rtl/counter_log_fifo.sv | 93 +++++++++
 rtl/counter_event_log.sv | 93 +++++++++
 tb/tb_counter_event_log.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_log_pkg.sv
// counter_log_pkg: shared constants and the record packer for the counter event log.
//   TS_W / REC_W     : timestamp and record widths
//   *_LSB / *_WID    : record field placement
//   pack_rec()       : builds one 32-bit log record from its fields
package counter_log_pkg;

  localparam int TS_W  = 16;
  localparam int REC_W = 32;

  localparam int TS_LSB    = 16;
  localparam int TS_WID    = 16;
  localparam int WRAP_LSB  = 12;
  localparam int WRAP_WID  = 1;
  localparam int MASK_LSB  = 8;
  localparam int MASK_WID  = 4;
  localparam int VALUE_LSB = 0;
  localparam int VALUE_WID = 8;

  // Bits [15:13] stay zero.
  function automatic logic [REC_W-1:0] pack_rec(
    input logic [TS_W-1:0]      ts,
    input logic                 wrap,
    input logic [MASK_WID-1:0]  mask,
    input logic [VALUE_WID-1:0] value
  );
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[TS_LSB +: TS_WID]       = ts;
    rec[WRAP_LSB +: WRAP_WID]   = wrap;
    rec[MASK_LSB +: MASK_WID]   = mask;
    rec[VALUE_LSB +: VALUE_WID] = value;
    return rec;
  endfunction

endpackage

// File: rtl/counter_log_fifo.sv
// counter_log_fifo: DEPTH x 32 synchronous first-word fall-through FIFO.
//   sys_clk, reset : clock, async active-high reset
//   clear          : synchronous flush, priority over push/pop
//   push, din      : write request and data (accepted when not full, or full with a pop)
//   pop            : remove head (ignored when empty)
//   dout           : registered head record, 0 when empty
//   level          : records stored; full/empty decoded from it
module counter_log_fifo
  import counter_log_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         din,
  output logic [REC_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [REC_W-1:0] r_dout;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_next;
  logic [REC_W-1:0] w_head_nxt;

  assign empty = (r_level == '0);
  assign full  = (r_level == LVL_FULL);
  assign level = r_level;
  assign dout  = r_dout;

  assign w_do_pop  = pop && !clear && !empty;
  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign w_do_push = push && !clear && (!full || w_do_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;

  // Head register is precomputed so dout comes straight from a flop.
  always_comb begin
    w_head_nxt = r_dout;
    if (w_do_pop) begin
      if (r_level == LVL_ONE)
        w_head_nxt = w_do_push ? din : '0;
      else
        w_head_nxt = r_mem[w_rd_next];
    end else if (empty && w_do_push) begin
      w_head_nxt = din;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else begin
      r_dout <= w_head_nxt;
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/counter_event_log.sv
// counter_event_log: timestamped recorder for counter compare strobes.
//   sys_clk, reset  : clock, async active-high reset
//   enable          : gates timestamp and captures
//   clear           : synchronous flush of FIFO, timestamp and statistics
//   evt_strobe      : N_EVT one-cycle event pulses; evt_value is the count sampled with them
//   pop             : host pop of the head record
//   rd_data/rd_valid: head record (0 when empty) / FIFO not empty
//   level           : records stored
//   overflow        : sticky drop flag; drop_count saturates at 255
module counter_event_log
  import counter_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int N_EVT = 2
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [N_EVT-1:0]       evt_strobe,
  input  logic [7:0]             evt_value,
  input  logic                   pop,
  output logic [REC_W-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  logic [TS_W-1:0]     r_ts;
  logic                r_overflow;
  logic [7:0]          r_drop_count;

  logic                w_wrap;
  logic [MASK_WID-1:0] w_mask;
  logic                w_cap;
  logic                w_drop;
  logic [REC_W-1:0]    w_rec;
  logic                w_full;
  logic                w_empty;

  assign w_wrap = (r_ts == '1);

  always_comb begin
    w_mask = '0;
    w_mask[N_EVT-1:0] = evt_strobe;
  end

  // A clear cycle discards its own capture.
  assign w_cap  = enable && !clear && ((|evt_strobe) || w_wrap);
  assign w_rec  = pack_rec(r_ts, w_wrap, w_mask, evt_value);
  assign w_drop = w_cap && w_full && !pop;

  counter_log_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clear   (clear),
    .push    (w_cap),
    .pop     (pop),
    .din     (w_rec),
    .dout    (rd_data),
    .level   (level),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign rd_valid   = !w_empty;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ts         <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_ts         <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (enable)
        r_ts <= r_ts + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF)
          r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_event_log.sv
module tb_counter_event_log;

  localparam int DEPTH = 16;
  localparam int N_EVT = 2;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [1:0]  evt_strobe;
  logic [7:0]  evt_value;
  logic        pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: plain queue of records plus counters
  logic [31:0] q[$];
  int m_ts, m_ovf, m_drop;

  always #5 sys_clk = ~sys_clk;

  counter_event_log #(.DEPTH(DEPTH), .N_EVT(N_EVT)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .evt_strobe (evt_strobe),
    .evt_value  (evt_value),
    .pop        (pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0;
    m_ovf = 0;
    m_drop = 0;
  endtask

  // One clock of the behavioural rules, using the inputs present before the edge.
  task automatic model_step();
    int rec;
    bit cap;
    bit wrap;
    if (clear) begin
      model_reset();
    end else begin
      wrap = (m_ts == 16'hFFFF);
      cap  = enable && (evt_strobe != 0 || wrap);
      rec  = (m_ts << 16) | (int'(wrap) << 12) | (int'(evt_strobe) << 8) | int'(evt_value);
      if (pop && q.size() > 0)
        void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(rec);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (enable) m_ts = (m_ts + 1) & 16'hFFFF;
    end
  endtask

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("rd_data", rd_data, (q.size() != 0) ? q[0] : 32'h0);
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input bit do_chk);
    model_step();
    @(posedge sys_clk);
    #1;
    if (do_chk) check_all();
    pop = 1'b0;
    clear = 1'b0;
    evt_strobe = '0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    evt_strobe = '0;
    evt_value = '0;
    pop = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all();
    reset = 1'b0;
    enable = 1'b1;

    // basic capture at ts=0x0005
    while (m_ts != 5) step(1);
    evt_strobe = 2'b01;
    evt_value = 8'h80;
    step(1);
    chk("basic_rec", rd_data, 32'h0005_0180);
    chk("basic_level", 32'(level), 32'd1);
    pop = 1'b1;
    step(1);
    chk("basic_pop_valid", 32'(rd_valid), 32'd0);
    chk("basic_pop_data", rd_data, 32'h0);

    // simultaneous strobes at ts=0x0010
    while (m_ts != 16'h10) step(1);
    evt_strobe = 2'b11;
    evt_value = 8'h00;
    step(1);
    chk("simul_rec", rd_data, 32'h0010_0300);
    chk("simul_level", 32'(level), 32'd1);
    pop = 1'b1;
    step(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 59) == 0);
      pop        = ($urandom_range(0, 2) == 0);
      evt_strobe = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      evt_value  = 8'($urandom);
      step(1);
    end

    // wrap marker
    enable = 1'b1;
    clear = 1'b1;
    step(1);
    evt_value = 8'h00;
    while (m_ts != 16'hFFFF) step(0);
    check_all();
    evt_value = 8'h5A;
    step(1);
    chk("wrap_marker", rd_data, 32'hFFFF_105A);
    evt_strobe = 2'b01;
    evt_value = 8'h11;
    pop = 1'b1;
    step(1);
    chk("ts_after_wrap", rd_data, 32'h0000_0111);

    // overflow: 20 pushes into 16 slots
    clear = 1'b1;
    step(1);
    for (int i = 0; i < 20; i++) begin
      evt_strobe = 2'b01;
      evt_value = 8'(i);
      step(1);
    end
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", 32'(rd_data[7:0]), 32'(i));
      pop = 1'b1;
      step(1);
    end
    for (int i = 0; i < 16; i++) begin
      evt_strobe = 2'b10;
      evt_value = 8'(i + 8'h40);
      step(1);
    end
    evt_strobe = 2'b01;
    evt_value = 8'hEE;
    pop = 1'b1;
    step(1);
    chk("full_pushpop_level", 32'(level), 32'd16);
    chk("full_pushpop_drops", 32'(drop_count), 32'd4);

    // saturation then clear with a strobe
    for (int i = 0; i < 300; i++) begin
      evt_strobe = 2'b01;
      step(0);
    end
    check_all();
    chk("drop_sat", 32'(drop_count), 32'd255);
    clear = 1'b1;
    evt_strobe = 2'b10;
    step(1);
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk("clr_valid", 32'(rd_valid), 32'd0);
    evt_strobe = 2'b01;
    evt_value = 8'h33;
    step(1);
    chk("clr_ts_zero", rd_data, 32'h0000_0133);

    // reset mid-operation with 5 records stored
    for (int i = 0; i < 4; i++) begin
      evt_strobe = 2'b11;
      evt_value = 8'(i);
      step(1);
    end
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_data", rd_data, 32'h0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      evt_strobe = 2'b01;
      evt_value = 8'h77;
      step(1);
    end
    pop = 1'b1;
    step(1);
    chk("pop_empty_level", 32'(level), 32'd0);
    enable = 1'b1;
    evt_strobe = 2'b01;
    evt_value = 8'h44;
    step(1);
    chk("ts_held", rd_data, 32'h0000_0144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
